// File: rtl/instr_fetch_unit.sv
// Fetch sequencer: owns the PC, drives the instruction ROM address and registers
// each fetched word with its PC for decode. Handles stall, branch redirect and halt.
module instr_fetch_unit #(
  parameter int          ADDR_W  = 8,
  parameter int          INSTR_W = 10,
  parameter logic [3:0]  HALT_OP = 4'b1111
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stall,
  input  logic               branch_taken,
  input  logic [ADDR_W-1:0]  branch_target,
  output logic [ADDR_W-1:0]  inst_address,
  input  logic [INSTR_W-1:0] inst_in,
  output logic [INSTR_W-1:0] instr_out,
  output logic [ADDR_W-1:0]  instr_pc,
  output logic               instr_valid,
  output logic               halted
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_FETCH  = 2'd1,
    S_HALTED = 2'd2
  } state_t;

  state_t              r_state, w_state_next;
  logic [ADDR_W-1:0]   r_pc, w_pc_next;
  logic [INSTR_W-1:0]  r_instr, w_instr_next;
  logic [ADDR_W-1:0]   r_instr_pc, w_instr_pc_next;
  logic                r_valid, w_valid_next;
  logic                r_halted, w_halted_next;
  logic                w_is_halt;

  assign w_is_halt = (inst_in[INSTR_W-1 -: 4] == HALT_OP);

  always_comb begin
    w_state_next    = r_state;
    w_pc_next       = r_pc;
    w_instr_next    = r_instr;
    w_instr_pc_next = r_instr_pc;
    w_valid_next    = r_valid;
    w_halted_next   = r_halted;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_pc_next    = '0;
          w_state_next = S_FETCH;
        end
      end
      S_FETCH: begin
        if (!stall) begin
          // A taken branch only counts against a live instruction; the word
          // arriving this cycle is on the wrong path and is dropped.
          if (branch_taken && r_valid) begin
            w_pc_next    = branch_target;
            w_valid_next = 1'b0;
          end else begin
            w_instr_next    = inst_in;
            w_instr_pc_next = r_pc;
            w_valid_next    = 1'b1;
            if (w_is_halt) begin
              w_state_next  = S_HALTED;
              w_halted_next = 1'b1;
            end else begin
              w_pc_next = r_pc + ADDR_W'(1);
            end
          end
        end
      end
      S_HALTED: begin
        if (start) begin
          w_pc_next     = '0;
          w_halted_next = 1'b0;
          w_valid_next  = 1'b0;
          w_state_next  = S_FETCH;
        end else if (!stall) begin
          w_valid_next = 1'b0;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_pc       <= '0;
      r_instr    <= '0;
      r_instr_pc <= '0;
      r_valid    <= 1'b0;
      r_halted   <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_pc       <= w_pc_next;
      r_instr    <= w_instr_next;
      r_instr_pc <= w_instr_pc_next;
      r_valid    <= w_valid_next;
      r_halted   <= w_halted_next;
    end
  end

  assign inst_address = r_pc;
  assign instr_out    = r_instr;
  assign instr_pc     = r_instr_pc;
  assign instr_valid  = r_valid;
  assign halted       = r_halted;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed program scenarios plus a
// randomized run, all compared against a cycle-level model of the fetch rules.
module tb_instr_fetch_unit;

  logic       clk = 1'b0;
  logic       rst_n, start, stall, branch_taken;
  logic [7:0] branch_target;
  logic [7:0] inst_address;
  logic [9:0] inst_in;
  logic [9:0] instr_out;
  logic [7:0] instr_pc;
  logic       instr_valid, halted;

  logic [9:0] rom [256];
  assign inst_in = rom[inst_address];

  always #5 clk = ~clk;

  instr_fetch_unit dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stall(stall),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .inst_address(inst_address), .inst_in(inst_in),
    .instr_out(instr_out), .instr_pc(instr_pc),
    .instr_valid(instr_valid), .halted(halted)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: 0 = idle, 1 = running, 2 = stopped on halt.
  int         m_mode;
  logic [7:0] m_pc, m_ipc;
  logic [9:0] m_instr;
  logic       m_valid, m_halted;

  task automatic model_reset();
    m_mode = 0; m_pc = 0; m_ipc = 0; m_instr = 0; m_valid = 0; m_halted = 0;
  endtask

  task automatic model_edge(input logic rn, st, sl, bt, input logic [7:0] tg);
    logic [9:0] w;
    if (!rn) begin
      model_reset();
    end else if (m_mode == 0) begin
      if (st) begin m_pc = 0; m_mode = 1; end
    end else if (m_mode == 1) begin
      if (!sl) begin
        if (bt && m_valid) begin
          m_pc = tg; m_valid = 0;
        end else begin
          w = rom[m_pc];
          m_instr = w; m_ipc = m_pc; m_valid = 1;
          if (w[9:6] == 4'hF) begin
            m_mode = 2; m_halted = 1;
          end else begin
            m_pc = 8'((int'(m_pc) + 1) % 256);
          end
        end
      end
    end else begin
      if (st) begin m_pc = 0; m_halted = 0; m_valid = 0; m_mode = 1; end
      else if (!sl) m_valid = 0;
    end
  endtask

  // One clock: drive inputs, advance model, sample outputs 1 time unit after the edge.
  task automatic step(input logic rn, st, sl, bt, input logic [7:0] tg);
    rst_n = rn; start = st; stall = sl; branch_taken = bt; branch_target = tg;
    check("addr_pre", inst_address, m_pc);
    @(posedge clk);
    model_edge(rn, st, sl, bt, tg);
    #1;
    check("instr_valid", instr_valid, m_valid);
    check("halted", halted, m_halted);
    check("addr", inst_address, m_pc);
    if (m_valid) begin
      check("instr_out", instr_out, m_instr);
      check("instr_pc", instr_pc, m_ipc);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 0, 0, 8'h00);
  endtask

  task automatic load_prog(input logic [9:0] w3);
    for (int i = 0; i < 256; i++) rom[i] = 10'h001;
    rom[0] = 10'h001; rom[1] = 10'h049; rom[2] = 10'h081; rom[3] = w3;
  endtask

  task automatic do_reset();
    step(0, 0, 0, 0, 8'h00);
  endtask

  initial begin
    rst_n = 0; start = 0; stall = 0; branch_taken = 0; branch_target = 0;
    model_reset();
    for (int i = 0; i < 256; i++) rom[i] = 10'h001;
    #1;

    // Basic program ending in halt.
    load_prog(10'h3FF);
    do_reset();
    check("rst_valid", instr_valid, 0);
    check("rst_addr", inst_address, 0);
    check("rst_halted", halted, 0);
    idle(2);
    check("idle_addr", inst_address, 0);
    step(1, 1, 0, 0, 8'h00);
    step(1, 0, 0, 0, 8'h00); check("seq0", {instr_pc, instr_out}, {8'd0, 10'h001});
    step(1, 0, 0, 0, 8'h00); check("seq1", {instr_pc, instr_out}, {8'd1, 10'h049});
    step(1, 0, 0, 0, 8'h00); check("seq2", {instr_pc, instr_out}, {8'd2, 10'h081});
    step(1, 0, 0, 0, 8'h00); check("seq3", {instr_pc, instr_out}, {8'd3, 10'h3FF});
    check("halt_set", halted, 1);
    step(1, 0, 0, 1, 8'h20);
    check("halt_frozen", inst_address, 3);
    check("halt_drop_valid", instr_valid, 0);
    idle(2);
    // Restart from halted.
    step(1, 1, 0, 0, 8'h00);
    check("restart_halted", halted, 0);
    check("restart_addr", inst_address, 0);
    step(1, 0, 0, 0, 8'h00);
    check("restart_pc0", instr_pc, 0);

    // Stall while instr_pc = 1.
    do_reset();
    step(1, 1, 0, 0, 8'h00);
    step(1, 0, 0, 0, 8'h00);
    step(1, 0, 0, 0, 8'h00);
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 1, 1, 8'h40);
      check("stall_ipc", instr_pc, 1);
      check("stall_out", instr_out, 10'h049);
      check("stall_addr", inst_address, 2);
    end
    step(1, 0, 0, 0, 8'h00);
    check("unstall_ipc", instr_pc, 2);
    idle(3);

    // Taken branch back to 1 while instr_pc = 3.
    load_prog(10'h0C9);
    do_reset();
    step(1, 1, 0, 0, 8'h00);
    idle(4);
    check("br_at3", instr_pc, 3);
    step(1, 0, 0, 1, 8'd1);
    check("br_bubble", instr_valid, 0);
    step(1, 0, 0, 0, 8'h00);
    check("br_target", instr_pc, 1);

    // Branch resolves while ROM returns halt: squashed, no halt.
    load_prog(10'h3FF);
    do_reset();
    step(1, 1, 0, 0, 8'h00);
    idle(3);
    step(1, 0, 0, 1, 8'd0);
    check("br_halt_nohalt", halted, 0);
    step(1, 0, 0, 0, 8'h00);
    check("br_halt_resume", instr_pc, 0);
    check("br_halt_nohalt2", halted, 0);

    // PC wrap over a ROM with no halts.
    for (int i = 0; i < 256; i++) rom[i] = 10'(i & 10'h1FF);
    do_reset();
    step(1, 1, 0, 0, 8'h00);
    for (int n = 1; n <= 258; n++) begin
      step(1, 0, 0, 0, 8'h00);
      if (n == 255) check("wrap_254", instr_pc, 254);
      if (n == 256) check("wrap_255", instr_pc, 255);
      if (n == 257) check("wrap_0", instr_pc, 0);
      if (n == 258) check("wrap_1", instr_pc, 1);
    end

    // Reset mid-fetch at PC 5; needs a new start.
    do_reset();
    step(1, 1, 0, 0, 8'h00);
    idle(5);
    check("pre_rst_addr", inst_address, 5);
    do_reset();
    check("midrst_valid", instr_valid, 0);
    check("midrst_addr", inst_address, 0);
    idle(3);
    check("midrst_idle", instr_valid, 0);
    step(1, 1, 0, 0, 8'h00);
    step(1, 0, 0, 0, 8'h00);
    check("midrst_resume", instr_pc, 0);

    // Randomized run.
    for (int i = 0; i < 256; i++) begin
      logic [9:0] w;
      w = 10'($urandom);
      if ($urandom_range(0, 11) == 0) w[9:6] = 4'hF;
      else if (w[9:6] == 4'hF) w[9] = 1'b0;
      rom[i] = w;
    end
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      step(($urandom_range(0, 149) != 0), ($urandom_range(0, 14) == 0),
           ($urandom_range(0, 3) == 0), ($urandom_range(0, 5) == 0),
           8'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
